// File: rtl/rs_ldst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : rs_ldst_queue_pkg
// Shared widths, entry record and helpers for the load/store reservation queue.
// Rev    : 1.0
// ============================================================================
package rs_ldst_queue_pkg;

    localparam int RV32_DATA_WIDTH = 32;
    localparam int RRF_ENT_SEL     = 6;

    typedef logic [RV32_DATA_WIDTH-1:0] data_t;
    typedef logic [RRF_ENT_SEL-1:0]     tag_t;

    // An operand with vld=0 carries its producer tag in the low RRF_ENT_SEL bits.
    typedef struct packed {
        logic  busy;
        logic  rs1_vld;
        data_t rs1;
        logic  rs2_vld;
        data_t rs2;
        data_t imm;
        logic  is_st;
        tag_t  rrftag;
    } rs_ent_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_ldst_queue_srcopr_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module : srcopr_fwd_mux
// Operand wakeup: a pending operand captures the lowest-index matching result.
// Rev    : 1.0
// ============================================================================
module srcopr_fwd_mux
    import rs_ldst_queue_pkg::*;
#(
    parameter int NUM_FWD = 3
) (
    input  logic                               i_src_vld,
    input  logic [RV32_DATA_WIDTH-1:0]         i_src,
    input  logic [NUM_FWD-1:0]                 i_fwd_vld,
    input  logic [NUM_FWD*RRF_ENT_SEL-1:0]     i_fwd_rrftag,
    input  logic [NUM_FWD*RV32_DATA_WIDTH-1:0] i_fwd_res,
    output logic                               o_src_vld,
    output logic [RV32_DATA_WIDTH-1:0]         o_src
);

    always_comb begin
        o_src_vld = i_src_vld;
        o_src     = i_src;
        // Scan high to low so the lowest matching channel is the final writer.
        for (int c = NUM_FWD - 1; c >= 0; c--) begin
            if (!i_src_vld && i_fwd_vld[c] &&
                (i_fwd_rrftag[c*RRF_ENT_SEL +: RRF_ENT_SEL] == i_src[RRF_ENT_SEL-1:0])) begin
                o_src_vld = 1'b1;
                o_src     = i_fwd_res[c*RV32_DATA_WIDTH +: RV32_DATA_WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_ldst_queue.sv
`default_nettype none
// ============================================================================
// Module : rs_ldst_queue
// In-order load/store reservation station with multi-slot dispatch and wakeup.
// Rev    : 1.0
// ============================================================================
module rs_ldst_queue
    import rs_ldst_queue_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int DP_WIDTH = 2,
    parameter int NUM_FWD  = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_flush,
    input  logic [DP_WIDTH-1:0]                 i_dp_en,
    input  logic [DP_WIDTH-1:0]                 i_dp_rs1_srcopr_vld,
    input  logic [DP_WIDTH-1:0]                 i_dp_rs2_srcopr_vld,
    input  logic [DP_WIDTH*RV32_DATA_WIDTH-1:0] i_dp_rs1_srcopr,
    input  logic [DP_WIDTH*RV32_DATA_WIDTH-1:0] i_dp_rs2_srcopr,
    input  logic [DP_WIDTH*RV32_DATA_WIDTH-1:0] i_dp_imm,
    input  logic [DP_WIDTH-1:0]                 i_dp_is_st,
    input  logic [DP_WIDTH*RRF_ENT_SEL-1:0]     i_dp_rrftag,
    output logic [$clog2(RS_DEPTH+1)-1:0]       o_free_cnt,
    input  logic [NUM_FWD-1:0]                  i_fwd_vld,
    input  logic [NUM_FWD*RRF_ENT_SEL-1:0]      i_fwd_rrftag,
    input  logic [NUM_FWD*RV32_DATA_WIDTH-1:0]  i_fwd_res,
    output logic                                o_iss_vld,
    input  logic                                i_iss_rdy,
    output logic [RV32_DATA_WIDTH-1:0]          o_iss_rs1_srcopr,
    output logic [RV32_DATA_WIDTH-1:0]          o_iss_rs2_srcopr,
    output logic [RV32_DATA_WIDTH-1:0]          o_iss_imm,
    output logic                                o_iss_is_st,
    output logic [RRF_ENT_SEL-1:0]              o_iss_rrftag
);

    localparam int PTR_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    rs_ent_t          ent_q [RS_DEPTH];
    rs_ent_t          ent_d [RS_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free_q;

    logic             w_ent_rs1_vld [RS_DEPTH];
    logic             w_ent_rs2_vld [RS_DEPTH];
    data_t            w_ent_rs1     [RS_DEPTH];
    data_t            w_ent_rs2     [RS_DEPTH];
    logic             w_dp_rs1_vld  [DP_WIDTH];
    logic             w_dp_rs2_vld  [DP_WIDTH];
    data_t            w_dp_rs1      [DP_WIDTH];
    data_t            w_dp_rs2      [DP_WIDTH];
    logic             w_iss_fire;
    logic [CNT_W-1:0] w_dp_cnt;
    logic [PTR_W-1:0] w_slot_ptr;

    for (genvar e = 0; e < RS_DEPTH; e++) begin : g_ent
        srcopr_fwd_mux #(.NUM_FWD(NUM_FWD)) u_rs1 (
            .i_src_vld(ent_q[e].rs1_vld), .i_src(ent_q[e].rs1),
            .i_fwd_vld(i_fwd_vld), .i_fwd_rrftag(i_fwd_rrftag), .i_fwd_res(i_fwd_res),
            .o_src_vld(w_ent_rs1_vld[e]), .o_src(w_ent_rs1[e])
        );
        srcopr_fwd_mux #(.NUM_FWD(NUM_FWD)) u_rs2 (
            .i_src_vld(ent_q[e].rs2_vld), .i_src(ent_q[e].rs2),
            .i_fwd_vld(i_fwd_vld), .i_fwd_rrftag(i_fwd_rrftag), .i_fwd_res(i_fwd_res),
            .o_src_vld(w_ent_rs2_vld[e]), .o_src(w_ent_rs2[e])
        );
    end

    // Dispatch slots see the same broadcast so a result arriving with the operand is kept.
    for (genvar s = 0; s < DP_WIDTH; s++) begin : g_dp
        srcopr_fwd_mux #(.NUM_FWD(NUM_FWD)) u_rs1 (
            .i_src_vld(i_dp_rs1_srcopr_vld[s]),
            .i_src(i_dp_rs1_srcopr[s*RV32_DATA_WIDTH +: RV32_DATA_WIDTH]),
            .i_fwd_vld(i_fwd_vld), .i_fwd_rrftag(i_fwd_rrftag), .i_fwd_res(i_fwd_res),
            .o_src_vld(w_dp_rs1_vld[s]), .o_src(w_dp_rs1[s])
        );
        srcopr_fwd_mux #(.NUM_FWD(NUM_FWD)) u_rs2 (
            .i_src_vld(i_dp_rs2_srcopr_vld[s]),
            .i_src(i_dp_rs2_srcopr[s*RV32_DATA_WIDTH +: RV32_DATA_WIDTH]),
            .i_fwd_vld(i_fwd_vld), .i_fwd_rrftag(i_fwd_rrftag), .i_fwd_res(i_fwd_res),
            .o_src_vld(w_dp_rs2_vld[s]), .o_src(w_dp_rs2[s])
        );
    end

    assign o_iss_vld        = (count_q != '0) && ent_q[head_q].rs1_vld && ent_q[head_q].rs2_vld;
    assign o_iss_rs1_srcopr = ent_q[head_q].rs1;
    assign o_iss_rs2_srcopr = ent_q[head_q].rs2;
    assign o_iss_imm        = ent_q[head_q].imm;
    assign o_iss_is_st      = ent_q[head_q].is_st;
    assign o_iss_rrftag     = ent_q[head_q].rrftag;
    assign o_free_cnt       = free_q;

    assign w_iss_fire = o_iss_vld & i_iss_rdy;
    assign w_dp_cnt   = CNT_W'(popcount(32'(i_dp_en)));

    always_comb begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            ent_d[e] = ent_q[e];
            if (ent_q[e].busy) begin
                ent_d[e].rs1_vld = w_ent_rs1_vld[e];
                ent_d[e].rs1     = w_ent_rs1[e];
                ent_d[e].rs2_vld = w_ent_rs2_vld[e];
                ent_d[e].rs2     = w_ent_rs2[e];
            end
        end
        if (w_iss_fire) begin
            ent_d[head_q].busy = 1'b0;
        end
        // Written after the pop so a full queue can refill the slot just issued.
        w_slot_ptr = tail_q;
        for (int s = 0; s < DP_WIDTH; s++) begin
            if (i_dp_en[s]) begin
                ent_d[w_slot_ptr] = '{busy:    1'b1,
                                      rs1_vld: w_dp_rs1_vld[s],
                                      rs1:     w_dp_rs1[s],
                                      rs2_vld: w_dp_rs2_vld[s],
                                      rs2:     w_dp_rs2[s],
                                      imm:     i_dp_imm[s*RV32_DATA_WIDTH +: RV32_DATA_WIDTH],
                                      is_st:   i_dp_is_st[s],
                                      rrftag:  i_dp_rrftag[s*RRF_ENT_SEL +: RRF_ENT_SEL]};
                w_slot_ptr = w_slot_ptr + 1'b1;
            end
        end
        head_d  = head_q + PTR_W'(w_iss_fire);
        tail_d  = tail_q + PTR_W'(w_dp_cnt);
        count_d = count_q + w_dp_cnt - CNT_W'(w_iss_fire);
        if (i_flush) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                ent_d[e].busy    = 1'b0;
                ent_d[e].rs1_vld = 1'b0;
                ent_d[e].rs2_vld = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= CNT_W'(RS_DEPTH);
            for (int e = 0; e < RS_DEPTH; e++) begin
                ent_q[e].busy    <= 1'b0;
                ent_q[e].rs1_vld <= 1'b0;
                ent_q[e].rs2_vld <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            free_q  <= CNT_W'(RS_DEPTH) - count_d;
            for (int e = 0; e < RS_DEPTH; e++) begin
                ent_q[e] <= ent_d[e];
            end
        end
    end

`ifndef SYNTHESIS
    // The entry popped this cycle counts as free, which allows full-to-full streaming.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (w_dp_cnt <= free_q + CNT_W'(w_iss_fire))
                else $error("rs_ldst_queue: dispatch overflows free entries");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_ldst_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_rs_ldst_queue
// Scoreboard bench: directed scenarios plus randomized dispatch/wakeup/issue.
// Rev    : 1.0
// ============================================================================
module tb_rs_ldst_queue;
    import rs_ldst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int DPW   = 2;
    localparam int NF    = 3;
    localparam int DW    = RV32_DATA_WIDTH;
    localparam int TW    = RRF_ENT_SEL;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          i_flush;
    logic [DPW-1:0]                i_dp_en, i_dp_rs1_srcopr_vld, i_dp_rs2_srcopr_vld, i_dp_is_st;
    logic [DPW*DW-1:0]             i_dp_rs1_srcopr, i_dp_rs2_srcopr, i_dp_imm;
    logic [DPW*TW-1:0]             i_dp_rrftag;
    logic [$clog2(DEPTH+1)-1:0]    o_free_cnt;
    logic [NF-1:0]                 i_fwd_vld;
    logic [NF*TW-1:0]              i_fwd_rrftag;
    logic [NF*DW-1:0]              i_fwd_res;
    logic                          o_iss_vld, i_iss_rdy, o_iss_is_st;
    logic [DW-1:0]                 o_iss_rs1_srcopr, o_iss_rs2_srcopr, o_iss_imm;
    logic [TW-1:0]                 o_iss_rrftag;

    always #5 clk = ~clk;

    rs_ldst_queue #(.RS_DEPTH(DEPTH), .DP_WIDTH(DPW), .NUM_FWD(NF)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_dp_en(i_dp_en),
        .i_dp_rs1_srcopr_vld(i_dp_rs1_srcopr_vld), .i_dp_rs2_srcopr_vld(i_dp_rs2_srcopr_vld),
        .i_dp_rs1_srcopr(i_dp_rs1_srcopr), .i_dp_rs2_srcopr(i_dp_rs2_srcopr),
        .i_dp_imm(i_dp_imm), .i_dp_is_st(i_dp_is_st), .i_dp_rrftag(i_dp_rrftag),
        .o_free_cnt(o_free_cnt), .i_fwd_vld(i_fwd_vld), .i_fwd_rrftag(i_fwd_rrftag),
        .i_fwd_res(i_fwd_res), .o_iss_vld(o_iss_vld), .i_iss_rdy(i_iss_rdy),
        .o_iss_rs1_srcopr(o_iss_rs1_srcopr), .o_iss_rs2_srcopr(o_iss_rs2_srcopr),
        .o_iss_imm(o_iss_imm), .o_iss_is_st(o_iss_is_st), .o_iss_rrftag(o_iss_rrftag)
    );

    // Reference: a program-order list of operand readiness, plus the issue sequence.
    typedef struct { logic [TW-1:0] t1, t2; bit r1, r2; } mdl_t;
    typedef struct { logic [DW-1:0] rs1, rs2, imm; logic st; logic [TW-1:0] tag; } exp_t;

    mdl_t          mq[$];
    exp_t          exp_q[$];
    logic [DW-1:0] tag_val [64];
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            mon_en  = 1'b0;
    int            nxt_tag = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit fwd_hit(input logic [TW-1:0] t);
        for (int c = 0; c < NF; c++) begin
            if (i_fwd_vld[c] && i_fwd_rrftag[c*TW +: TW] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_head_rdy();
        return (mq.size() > 0) && mq[0].r1 && mq[0].r2;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || i_flush) begin
            mq.delete();
            exp_q.delete();
        end else begin
            if (model_head_rdy() && i_iss_rdy) void'(mq.pop_front());
            foreach (mq[k]) begin
                if (!mq[k].r1 && fwd_hit(mq[k].t1)) mq[k].r1 = 1'b1;
                if (!mq[k].r2 && fwd_hit(mq[k].t2)) mq[k].r2 = 1'b1;
            end
            for (int s = 0; s < DPW; s++) begin
                if (i_dp_en[s]) begin
                    mdl_t m;
                    exp_t x;
                    m.t1 = i_dp_rs1_srcopr[s*DW +: TW];
                    m.t2 = i_dp_rs2_srcopr[s*DW +: TW];
                    m.r1 = i_dp_rs1_srcopr_vld[s] || fwd_hit(m.t1);
                    m.r2 = i_dp_rs2_srcopr_vld[s] || fwd_hit(m.t2);
                    mq.push_back(m);
                    x.rs1 = i_dp_rs1_srcopr_vld[s] ? i_dp_rs1_srcopr[s*DW +: DW] : tag_val[m.t1];
                    x.rs2 = i_dp_rs2_srcopr_vld[s] ? i_dp_rs2_srcopr[s*DW +: DW] : tag_val[m.t2];
                    x.imm = i_dp_imm[s*DW +: DW];
                    x.st  = i_dp_is_st[s];
                    x.tag = i_dp_rrftag[s*TW +: TW];
                    exp_q.push_back(x);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("free_cnt", 64'(o_free_cnt), 64'(DEPTH - mq.size()));
            check("iss_vld", 64'(o_iss_vld), 64'(model_head_rdy()));
            if (o_iss_vld && i_iss_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got tag %0h expected no issue", o_iss_rrftag);
                end else begin
                    e = exp_q.pop_front();
                    check("iss_rrftag", 64'(o_iss_rrftag), 64'(e.tag));
                    check("iss_rs1", 64'(o_iss_rs1_srcopr), 64'(e.rs1));
                    check("iss_rs2", 64'(o_iss_rs2_srcopr), 64'(e.rs2));
                    check("iss_imm", 64'(o_iss_imm), 64'(e.imm));
                    check("iss_is_st", 64'(o_iss_is_st), 64'(e.st));
                end
            end
        end
    end

    task automatic idle();
        i_flush = 1'b0; i_dp_en = '0; i_dp_rs1_srcopr_vld = '0; i_dp_rs2_srcopr_vld = '0;
        i_dp_is_st = '0; i_fwd_vld = '0; i_iss_rdy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [DW-1:0] wait_on(input logic [TW-1:0] t);
        logic [DW-1:0] v;
        v = $urandom();
        v[TW-1:0] = t;
        return v;
    endfunction

    task automatic put_slot(input int s, input bit v1, input logic [DW-1:0] o1,
                            input bit v2, input logic [DW-1:0] o2, input bit st);
        i_dp_en[s] = 1'b1;
        i_dp_rs1_srcopr_vld[s] = v1;
        i_dp_rs2_srcopr_vld[s] = v2;
        i_dp_rs1_srcopr[s*DW +: DW] = o1;
        i_dp_rs2_srcopr[s*DW +: DW] = o2;
        i_dp_imm[s*DW +: DW] = $urandom();
        i_dp_is_st[s] = st;
        i_dp_rrftag[s*TW +: TW] = TW'(nxt_tag);
        nxt_tag++;
    endtask

    task automatic put_ready(input int s);
        put_slot(s, 1'b1, $urandom(), 1'b1, $urandom(), 1'($urandom()));
    endtask

    task automatic set_fwd(input int c, input logic [TW-1:0] t, input logic [DW-1:0] v);
        i_fwd_vld[c] = 1'b1;
        i_fwd_rrftag[c*TW +: TW] = t;
        i_fwd_res[c*DW +: DW] = v;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            i_iss_rdy = 1'b1;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int t = 0; t < 64; t++) tag_val[t] = $urandom();
        tag_val[5] = 32'hDEAD;
        tag_val[9] = 32'h1234;
        idle();
        i_dp_rs1_srcopr = '0; i_dp_rs2_srcopr = '0; i_dp_imm = '0; i_dp_rrftag = '0;
        i_fwd_rrftag = '0; i_fwd_res = '0;
        step();
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        #1;
        check("reset_free", 64'(o_free_cnt), 64'(DEPTH));
        check("reset_iss_vld", 64'(o_iss_vld), 64'd0);

        // Fill with ready stores, nothing accepted
        for (int k = 0; k < 4; k++) begin
            put_slot(0, 1'b1, $urandom(), 1'b1, $urandom(), 1'b1);
            put_slot(1, 1'b1, $urandom(), 1'b1, $urandom(), 1'b1);
            step();
            #1;
            check("fill_free", 64'(o_free_cnt), 64'(6 - 2 * k));
            check("fill_iss_vld", 64'(o_iss_vld), 64'd1);
        end
        drain(10);

        // Head waits on tag 5 while the younger entry is ready
        put_slot(0, 1'b0, wait_on(6'd5), 1'b1, $urandom(), 1'b0);
        put_ready(1);
        step();
        for (int k = 0; k < 3; k++) begin
            i_iss_rdy = 1'b1;
            step();
            #1;
            check("block_iss_vld", 64'(o_iss_vld), 64'd0);
        end
        set_fwd(2, 6'd5, tag_val[5]);
        i_iss_rdy = 1'b1;
        step();
        #1;
        check("wake_iss_vld", 64'(o_iss_vld), 64'd1);
        check("wake_rs1", 64'(o_iss_rs1_srcopr), 64'h0000_DEAD);
        drain(3);

        // Result broadcast in the dispatch cycle
        put_slot(0, 1'b0, wait_on(6'd9), 1'b1, $urandom(), 1'b0);
        set_fwd(0, 6'd9, tag_val[9]);
        step();
        #1;
        check("bypass_iss_vld", 64'(o_iss_vld), 64'd1);
        check("bypass_rs1", 64'(o_iss_rs1_srcopr), 64'h0000_1234);
        drain(2);

        // Full queue streaming one in / one out across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            put_ready(0);
            put_ready(1);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            put_ready(1);
            i_iss_rdy = 1'b1;
            step();
            #1;
            check("wrap_free", 64'(o_free_cnt), 64'd0);
        end
        drain(10);

        // Flush beats simultaneous dispatch and issue
        for (int k = 0; k < 5; k++) begin
            put_ready(0);
            step();
        end
        put_ready(0);
        put_ready(1);
        i_iss_rdy = 1'b1;
        i_flush = 1'b1;
        step();
        #1;
        check("flush_free", 64'(o_free_cnt), 64'(DEPTH));
        check("flush_iss_vld", 64'(o_iss_vld), 64'd0);
        step();

        // Reset in mid-operation
        for (int k = 0; k < 3; k++) begin
            put_ready(0);
            step();
        end
        rst_n = 1'b0;
        put_ready(0);
        i_iss_rdy = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_free", 64'(o_free_cnt), 64'(DEPTH));
        check("midrst_iss_vld", 64'(o_iss_vld), 64'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int free_now;
            i_iss_rdy = ($urandom_range(0, 3) != 0);
            free_now = DEPTH - mq.size() + ((model_head_rdy() && i_iss_rdy) ? 1 : 0);
            for (int s = 0; s < DPW; s++) begin
                if (free_now > 0 && $urandom_range(0, 1) == 1) begin
                    bit v1, v2;
                    free_now--;
                    v1 = ($urandom_range(0, 2) != 0);
                    v2 = ($urandom_range(0, 2) != 0);
                    put_slot(s, v1, v1 ? $urandom() : wait_on(TW'($urandom_range(0, 15))),
                                v2, v2 ? $urandom() : wait_on(TW'($urandom_range(0, 15))),
                                1'($urandom()));
                end
            end
            for (int c = 0; c < NF; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    logic [TW-1:0] t;
                    bit dup;
                    t = TW'($urandom_range(0, 15));
                    dup = 1'b0;
                    for (int p = 0; p < c; p++) begin
                        if (i_fwd_vld[p] && i_fwd_rrftag[p*TW +: TW] == t) dup = 1'b1;
                    end
                    set_fwd(c, t, dup ? ~tag_val[t] : tag_val[t]);
                end
            end
            if ($urandom_range(0, 199) == 0) i_flush = 1'b1;
            step();
        end

        for (int k = 0; k < 40; k++) begin
            set_fwd(0, TW'(k % 16), tag_val[k % 16]);
            set_fwd(1, TW'((k + 8) % 16), tag_val[(k + 8) % 16]);
            i_iss_rdy = 1'b1;
            step();
        end
        #1;
        check("drain_free", 64'(o_free_cnt), 64'(DEPTH));
        check("drain_iss_vld", 64'(o_iss_vld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_ldst_queue.md
RS_LDST_QUEUE -- requirements
Module: rs_ldst_queue

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 8: entry count; power of two, at least 2.
REQ-002 SHALL have parameter DP_WIDTH, default 2: dispatch slots per cycle; 1 to RS_DEPTH; slot 0 is oldest.
REQ-003 SHALL have parameter NUM_FWD, default 3: result-forwarding channels (ALU, MUL, LD, ...).
REQ-004 SHALL use one clock and a synchronous, active-low reset.
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- i_flush  in  1  kill all entries
- i_dp_en  in  DP_WIDTH  per-slot dispatch valid
- i_dp_rs1_srcopr_vld, i_dp_rs2_srcopr_vld  in  DP_WIDTH  operand ready
- i_dp_rs1_srcopr, i_dp_rs2_srcopr  in  DP_WIDTH*RV32_DATA_WIDTH  value if ready, else rrftag in low RRF_ENT_SEL bits
- i_dp_imm  in  DP_WIDTH*RV32_DATA_WIDTH  immediate
- i_dp_is_st  in  DP_WIDTH  store flag
- i_dp_rrftag  in  DP_WIDTH*RRF_ENT_SEL  destination tag
- o_free_cnt  out  $clog2(RS_DEPTH+1)  free entries, registered
- i_fwd_vld  in  NUM_FWD  channel result valid this cycle
- i_fwd_rrftag  in  NUM_FWD*RRF_ENT_SEL  channel tag
- i_fwd_res  in  NUM_FWD*RV32_DATA_WIDTH  channel result
- o_iss_vld  out  1  head entry ready to issue
- i_iss_rdy  in  1  LSU accepts
- o_iss_rs1_srcopr, o_iss_rs2_srcopr, o_iss_imm  out  RV32_DATA_WIDTH each  head operands and immediate
- o_iss_is_st  out  1  head store flag
- o_iss_rrftag  out  RRF_ENT_SEL  head destination tag

Function
REQ-005 SHALL hold entries in program order in a circular buffer: head pointer, tail pointer, count; pointers wrap modulo RS_DEPTH.
REQ-006 SHALL write enabled dispatch slots to consecutive entries from tail, in slot order; disabled slots are skipped, so enabled slots need not be contiguous.
REQ-007 SHALL advance tail and count by popcount(i_dp_en).
REQ-008 Dispatch exceeding o_free_cnt SHALL be illegal and flagged by a simulation assertion.
REQ-009 o_free_cnt SHALL equal RS_DEPTH minus registered count; an entry freed by issue in cycle N SHALL be dispatchable from cycle N+1.
REQ-010 Each cycle, every busy entry operand with vld=0 SHALL compare its tag with each channel where i_fwd_vld=1. On a match it captures i_fwd_res and sets vld=1 at the next edge.
REQ-011 A dispatched operand with vld=0 SHALL be matched against the forward channels in its dispatch cycle, so a result broadcast in that cycle is not lost.
REQ-012 If several channels match, the lowest channel index SHALL win.
REQ-013 o_iss_vld SHALL be count!=0 AND head rs1 vld AND head rs2 vld, from registered state only. There is no same-cycle forward-to-issue path.
REQ-014 Issue SHALL be strictly in order, head only. A younger ready entry never bypasses a non-ready head, for both loads and stores.
REQ-015 o_iss_* SHALL reflect the head entry combinationally whenever o_iss_vld=1; they are don't-care otherwise.
REQ-016 When o_iss_vld AND i_iss_rdy, the head SHALL pop at the next edge and count SHALL decrement.
REQ-017 Simultaneous dispatch and issue SHALL update count by (dispatched minus 1), including the full-to-full case.
REQ-018 i_flush SHALL have priority over dispatch, issue and wakeup: head=tail=count=0 next cycle and all valid bits cleared.
REQ-019 Issue latency SHALL be one cycle: an entry dispatched with both operands ready in cycle N, or woken in cycle N, asserts o_iss_vld in cycle N+1 if it is at the head.

Reset
REQ-020 On rst_n=0 at a clock edge, count, head, tail and all entry valid bits SHALL clear and o_free_cnt SHALL read RS_DEPTH.
REQ-021 Reset SHALL override flush, dispatch and issue in the same cycle; entry payload need not be reset.
REQ-022 o_iss_vld SHALL be 0 from the first cycle after reset.

Structure
REQ-023 RV32_DATA_WIDTH and RRF_ENT_SEL SHALL come from constants.vh; no local redefinition.
REQ-024 Per-operand wakeup SHALL be a sub-module srcopr_fwd_mux, parametrised by NUM_FWD, instantiated twice per entry plus twice per dispatch slot.
REQ-025 Entry storage SHALL be flat registers indexed by pointer; no RAM macro.

Verification
REQ-026 Fill: reset, dispatch 2 ready stores per cycle for 4 cycles with i_iss_rdy=0 -> o_free_cnt 8,6,4,2,0; o_iss_vld=1 from cycle 2.
REQ-027 In-order block: head rs1 waits on tag 5 and entry 1 is ready -> o_iss_vld=0. Then fwd channel 2 broadcasts tag 5 with value 0xDEAD -> next cycle o_iss_vld=1 and o_iss_rs1_srcopr=0xDEAD.
REQ-028 Dispatch-cycle bypass: dispatch an operand waiting on tag 9 in the same cycle channel 0 broadcasts tag 9 with value 0x1234 -> entry issues next cycle with 0x1234.
REQ-029 Wrap and full: RS_DEPTH=4, full queue, issue 1 and dispatch 1 every cycle for 10 cycles -> count stays 4 and issued rrftags are in dispatch order across the pointer wrap.
REQ-030 Flush: 5 busy entries, i_flush with i_dp_en=2'b11 and handshake -> next cycle o_free_cnt=8, o_iss_vld=0, nothing written.
REQ-031 Reset mid-operation: rst_n low for 1 cycle with 3 entries -> o_free_cnt=8 and o_iss_vld=0 next cycle.
